// File: rtl/serial_add_sequencer_if.sv
// Bundle of the operand handshake, the 2-bit adder slice bus and the result
// handshake for serial_add_sequencer. "slave" is the sequencer's view.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_lhs;
    logic [WIDTH-1:0] io_in_rhs;
    logic             io_in_cin;
    logic [1:0]       io_add_lhs;
    logic [1:0]       io_add_rhs;
    logic             io_add_cin;
    logic [1:0]       io_add_out;
    logic             io_add_cout;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_cout;

    modport slave (
        input  io_in_valid, io_in_lhs, io_in_rhs, io_in_cin,
        input  io_add_out, io_add_cout, io_out_ready,
        output io_in_ready, io_add_lhs, io_add_rhs, io_add_cin,
        output io_out_valid, io_out_sum, io_out_cout
    );

    modport master (
        output io_in_valid, io_in_lhs, io_in_rhs, io_in_cin,
        output io_add_out, io_add_cout, io_out_ready,
        input  io_in_ready, io_add_lhs, io_add_rhs, io_add_cin,
        input  io_out_valid, io_out_sum, io_out_cout
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Feeds a WIDTH-bit operand pair to an external 2-bit carry-in adder one slice
// per cycle (LSB first) and returns the assembled sum plus final carry.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_add_sequencer_if.slave bus
);
    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] lhs_q, lhs_d;
    logic [WIDTH-1:0] rhs_q, rhs_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [1:0]       add_lhs_s;
    logic [1:0]       add_rhs_s;
    logic             add_cin_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            lhs_q   <= {WIDTH{1'b0}};
            rhs_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state, slice sequencing and adder-bus drive.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lhs_d     = lhs_q;
        rhs_d     = rhs_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        add_lhs_s = 2'b00;
        add_rhs_s = 2'b00;
        add_cin_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.io_in_valid) begin
                    lhs_d   = bus.io_in_lhs;
                    rhs_d   = bus.io_in_rhs;
                    carry_d = bus.io_in_cin;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                add_lhs_s = lhs_q[{idx_q, 1'b0} +: 2];
                add_rhs_s = rhs_q[{idx_q, 1'b0} +: 2];
                add_cin_s = carry_q;
                sum_d[{idx_q, 1'b0} +: 2] = bus.io_add_out;
                carry_d = bus.io_add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = bus.io_add_cout;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Sum and cout registers are untouched here, so they hold.
                if (bus.io_out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.io_in_ready  = (state_q == ST_IDLE);
    assign bus.io_out_valid = (state_q == ST_DONE);
    assign bus.io_out_sum   = sum_q;
    assign bus.io_out_cout  = cout_q;
    assign bus.io_add_lhs   = add_lhs_s;
    assign bus.io_add_rhs   = add_rhs_s;
    assign bus.io_add_cin   = add_cin_s;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer with a behavioural
// 2-bit adder and a whole-word arithmetic reference model.
module tb_serial_add_sequencer;
    localparam int W      = 8;
    localparam int SLICES = W / 2;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External 2-bit carry-in adder.
    assign {bus.io_add_cout, bus.io_add_out} =
        {1'b0, bus.io_add_lhs} + {1'b0, bus.io_add_rhs} + {2'b00, bus.io_add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // One complete operation; hold = DONE cycles with out_ready low,
    // scramble = keep in_valid high with random operands after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input int hold, input bit scramble);
        int lat;
        @(negedge clk);
        check_eq("idle_in_ready", 32'(bus.io_in_ready), 32'd1);
        check_eq("idle_add_bus", {27'd0, bus.io_add_lhs, bus.io_add_rhs, bus.io_add_cin}, 32'd0);
        bus.io_in_valid = 1'b1;
        bus.io_in_lhs   = a;
        bus.io_in_rhs   = b;
        bus.io_in_cin   = c;
        @(negedge clk);
        lat = 0;
        while (!bus.io_out_valid && lat < 4 * SLICES + 4) begin
            check_eq("run_in_ready", 32'(bus.io_in_ready), 32'd0);
            if (scramble) begin
                bus.io_in_lhs = W'($urandom);
                bus.io_in_rhs = W'($urandom);
                bus.io_in_cin = 1'($urandom);
            end else begin
                bus.io_in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(SLICES));
        check_eq("sum", 32'(bus.io_out_sum), 32'(exp_sum));
        check_eq("cout", 32'(bus.io_out_cout), 32'(exp_cout));
        check_eq("done_add_bus", {27'd0, bus.io_add_lhs, bus.io_add_rhs, bus.io_add_cin}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.io_out_ready = 1'b0;
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.io_out_valid), 32'd1);
            check_eq("hold_sum", 32'(bus.io_out_sum), 32'(exp_sum));
            check_eq("hold_cout", 32'(bus.io_out_cout), 32'(exp_cout));
            check_eq("hold_in_ready", 32'(bus.io_in_ready), 32'd0);
        end
        bus.io_out_ready = 1'b1;
        @(negedge clk);
        // in_valid may still be high here: that edge must not have accepted.
        check_eq("ret_out_valid", 32'(bus.io_out_valid), 32'd0);
        check_eq("ret_in_ready", 32'(bus.io_in_ready), 32'd1);
        bus.io_out_ready = 1'b0;
        bus.io_in_valid  = 1'b0;
    endtask

    initial begin
        logic [W:0] r;
        logic [W-1:0] a, b;
        logic c;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.io_in_valid  = 1'b0;
        bus.io_in_lhs    = '0;
        bus.io_in_rhs    = '0;
        bus.io_in_cin    = 1'b0;
        bus.io_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.io_in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
        check_eq("rst_sum", 32'(bus.io_out_sum), 32'd0);
        check_eq("rst_cout", 32'(bus.io_out_cout), 32'd0);
        reset = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h81, 8'h7E, 1'b1, 8'h00, 1'b1, 5, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 1'b1);

        // Reset in RUN with slice index 2 abandons the op.
        @(negedge clk);
        bus.io_in_valid = 1'b1;
        bus.io_in_lhs   = 8'hAB;
        bus.io_in_rhs   = 8'hCD;
        bus.io_in_cin   = 1'b1;
        @(negedge clk);
        bus.io_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_in_ready", 32'(bus.io_in_ready), 32'd1);
        check_eq("mid_rst_out_valid", 32'(bus.io_out_valid), 32'd0);
        check_eq("mid_rst_sum", 32'(bus.io_out_sum), 32'd0);
        check_eq("mid_rst_cout", 32'(bus.io_out_cout), 32'd0);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            r = ref_add(a, b, c);
            run_op(a, b, c, r[W-1:0], r[W], int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
